// File: rtl/dmem_pkg.sv
// Shared constants and types for the MEM-stage data memory responder.
// Imported by the responder and its lane-alignment helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32I loads and stores:
// builds the write mask and merged word, extends load data, flags bad accesses.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data,
    output logic        bad
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wr_rep;

    always_comb begin
        ld_byte   = old_word[8*addr_lo +: 8];
        ld_half   = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        byte_mask = 4'b0000;
        wr_rep    = wdata;
        ld_data   = 32'd0;
        bad       = 1'b1;

        case (funct3)
            F3_B: begin
                bad       = 1'b0;
                byte_mask = 4'b0001 << addr_lo;
                wr_rep    = {4{wdata[7:0]}};
                ld_data   = {{24{ld_byte[7]}}, ld_byte};
            end
            F3_BU: begin
                bad     = we;
                ld_data = {24'd0, ld_byte};
            end
            F3_H: begin
                bad       = addr_lo[0];
                byte_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_rep    = {2{wdata[15:0]}};
                ld_data   = {{16{ld_half[15]}}, ld_half};
            end
            F3_HU: begin
                bad     = we | addr_lo[0];
                ld_data = {16'd0, ld_half};
            end
            F3_W: begin
                bad       = |addr_lo;
                byte_mask = 4'b1111;
                ld_data   = old_word;
            end
            default: bad = 1'b1;
        endcase

        // Loads never write; stores and rejected accesses never return data.
        if (!we || bad) byte_mask = 4'b0000;
        if (we || bad)  ld_data   = 32'd0;

        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = byte_mask[i] ? wr_rep[8*i +: 8] : old_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder for the MEM stage: valid/ready request,
// one-cycle response pulse, and a combinational stall back to the pipeline.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_stall
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               enter_resp;

    logic               lat_we;
    logic [2:0]         lat_f3;
    logic [31:0]        lat_addr, lat_wdata;

    logic               acc_we;
    logic [2:0]         acc_f3;
    logic [31:0]        acc_addr, acc_wdata;
    logic [AW-1:0]      acc_idx;
    logic               acc_oor, acc_err, align_bad;
    logic [31:0]        old_word, wr_word, ld_data;
    logic [3:0]         byte_mask;

    logic [31:0]        mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_n    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request capture: only meaningful while idle, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // With LATENCY==1 the access happens on the accepting edge, before the latch holds it.
    always_comb begin
        acc_we    = (state == IDLE) ? req_we     : lat_we;
        acc_f3    = (state == IDLE) ? req_funct3 : lat_f3;
        acc_addr  = (state == IDLE) ? req_addr   : lat_addr;
        acc_wdata = (state == IDLE) ? req_wdata  : lat_wdata;
    end

    assign acc_idx  = acc_addr[AW+1:2];
    assign acc_oor  = (acc_addr >= ADDR_LIMIT);
    assign old_word = mem[acc_idx];
    assign acc_err  = acc_oor | align_bad;

    dmem_lane_align u_align (
        .we        (acc_we),
        .funct3    (acc_f3),
        .addr_lo   (acc_addr[1:0]),
        .wdata     (acc_wdata),
        .old_word  (old_word),
        .byte_mask (byte_mask),
        .wr_word   (wr_word),
        .ld_data   (ld_data),
        .bad       (align_bad)
    );

    always_ff @(posedge clk) begin
        if (enter_resp && !reset && !acc_oor && (|byte_mask)) begin
            mem[acc_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_rdata <= acc_err ? 32'd0 : ld_data;
            resp_err   <= acc_err;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_stall  = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against a byte-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_stall;
    logic [31:0] resp_rdata;

    logic        r3_valid, r3_we;
    logic [2:0]  r3_funct3;
    logic [31:0] r3_addr, r3_wdata;
    logic        r3_ready, r3_resp_valid, r3_err, r3_stall;
    logic [31:0] r3_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mb [256];
    logic [31:0] last_rd;
    logic        last_er;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_stall(mem_stall)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(r3_valid), .req_we(r3_we), .req_funct3(r3_funct3),
        .req_addr(r3_addr), .req_wdata(r3_wdata), .req_ready(r3_ready),
        .resp_valid(r3_resp_valid), .resp_rdata(r3_rdata), .resp_err(r3_err),
        .mem_stall(r3_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, little-endian, RV32I size/sign rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] erd, output logic eer);
        int sz;
        logic ill;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        eer = ill || (addr % sz != 0) || (addr >= 32'd256);
        erd = 32'd0;
        if (!eer) begin
            if (we) begin
                for (int i = 0; i < sz; i++) mb[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) erd = erd | (32'(mb[int'(addr) + i]) << (8*i));
                if (!f3[2] && sz < 4 && erd[8*sz-1]) erd = erd | (32'hFFFF_FFFF << (8*sz));
            end
        end
    endfunction

    // One transaction on the LATENCY=2 instance; starts and ends at a negedge with the DUT idle.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
        logic [31:0] erd;
        logic        eer;
        int          k;
        logic        got;
        model(we, f3, addr, wdata, erd, eer);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        chk1({tag, ".ready"}, req_ready, 1'b1);
        chk1({tag, ".stall_req"}, mem_stall, 1'b1);
        @(posedge clk);
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (resp_valid) got = 1'b1;
            else begin
                chk1({tag, ".stall_wait"}, mem_stall, 1'b1);
                chk1({tag, ".ready_wait"}, req_ready, 1'b0);
            end
        end
        chk({tag, ".latency"}, 32'(k), 32'd2);
        chk({tag, ".rdata"}, resp_rdata, erd);
        chk1({tag, ".err"}, resp_err, eer);
        chk1({tag, ".stall_resp"}, mem_stall, 1'b0);
        last_rd = resp_rdata;
        last_er = resp_err;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] keep20;
        logic [31:0] a, d;
        logic [2:0]  f;
        logic        w;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        r3_valid = 1'b0; r3_we = 1'b1; r3_funct3 = 3'd2; r3_addr = 32'd0; r3_wdata = 32'h1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("rst.ready", req_ready, 1'b1);
        chk1("rst.valid", resp_valid, 1'b0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk1("rst.err", resp_err, 1'b0);
        chk1("rst.stall", mem_stall, 1'b0);
        chk1("rst3.ready", r3_ready, 1'b1);
        @(negedge clk);

        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
        chk1("sw10.ok", last_er, 1'b0);
        xact(1'b0, 3'd0, 32'h13, 32'd0, "lb13");   chk("lb13.lit", last_rd, 32'hFFFFFFDE);
        xact(1'b0, 3'd4, 32'h13, 32'd0, "lbu13");  chk("lbu13.lit", last_rd, 32'h000000DE);
        xact(1'b0, 3'd1, 32'h12, 32'd0, "lh12");   chk("lh12.lit", last_rd, 32'hFFFFDEAD);
        xact(1'b0, 3'd5, 32'h10, 32'd0, "lhu10");  chk("lhu10.lit", last_rd, 32'h0000BEEF);
        xact(1'b0, 3'd2, 32'h10, 32'd0, "lw10");   chk("lw10.lit", last_rd, 32'hDEADBEEF);
        xact(1'b1, 3'd0, 32'h11, 32'h12345677, "sb11");
        xact(1'b0, 3'd2, 32'h10, 32'd0, "lw10b");  chk("lw10b.lit", last_rd, 32'hDEAD77EF);
        xact(1'b1, 3'd1, 32'h12, 32'h0000ABCD, "sh12");
        xact(1'b0, 3'd2, 32'h10, 32'd0, "lw10c");  chk("lw10c.lit", last_rd, 32'hABCD77EF);
        xact(1'b0, 3'd2, 32'h11, 32'd0, "lw11");   chk1("lw11.lit", last_er, 1'b1);
        xact(1'b1, 3'd1, 32'h13, 32'hFFFF, "sh13"); chk1("sh13.lit", last_er, 1'b1);
        xact(1'b0, 3'd2, 32'h100, 32'd0, "lw100"); chk1("lw100.lit", last_er, 1'b1);
        xact(1'b0, 3'd3, 32'h10, 32'd0, "ld_f3");  chk1("ldf3.lit", last_er, 1'b1);
        xact(1'b1, 3'd4, 32'h10, 32'd0, "st_f4");  chk1("stf4.lit", last_er, 1'b1);
        xact(1'b0, 3'd2, 32'h10, 32'd0, "lw10d");  chk("lw10d.lit", last_rd, 32'hABCD77EF);

        for (int i = 0; i < 64; i++) xact(1'b1, 3'd2, 32'(4*i), $urandom, "init");

        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 600)) : 32'($urandom_range(0, 255));
            d = $urandom;
            xact(w, f, a, d, "rand");
        end

        keep20 = {mb[35], mb[34], mb[33], mb[32]};
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        chk1("rstw.in_wait", req_ready, 1'b0);
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk1("rstw.valid", resp_valid, 1'b0);
        chk1("rstw.idle", req_ready, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("rstw.novalid", resp_valid, 1'b0);
        end
        xact(1'b0, 3'd2, 32'h20, 32'd0, "lw20");
        chk("lw20.keep", last_rd, keep20);

        r3_valid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            #1;
            chk1("b2b.ready", r3_ready, (n % 4) == 0);
            chk1("b2b.valid", r3_resp_valid, (n % 4) == 3);
            chk1("b2b.stall", r3_stall, (n % 4) != 3);
            @(negedge clk);
        end
        r3_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
